// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial shift-and-add-3 binary to BCD converter, one bit per clock
//   clk, rst_n      clock, asynchronous active-low reset
//   start, bin_in   conversion request and operand, sampled only while idle
//   busy, done      conversion in progress, one-cycle result-updated pulse
//   bcd_out         DIGITS BCD digits, digit 0 (ones) in the low nibble
//   overflow        bin_in did not fit in DIGITS digits; bcd_out holds bin_in mod 10^DIGITS
module bin2bcd_serial #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = BIN_W > 1 ? $clog2(BIN_W) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_next;
  logic [BIN_W-1:0] r_bin;
  logic [SW-1:0] r_scr, w_adj, w_scr_nxt, r_bcd;
  logic [CW-1:0] r_cnt;
  logic r_ovf, r_overflow, r_done, w_accept, w_last, w_ovf_nxt;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[4*g+:4] = r_scr[4*g+:4] >= 4'd5 ? r_scr[4*g+:4] + 4'd3 : r_scr[4*g+:4];
  end
  // the bit pushed out of the top digit is a carry into a digit we do not keep
  assign w_scr_nxt = {w_adj[SW-2:0], r_bin[BIN_W-1]};
  assign w_ovf_nxt = r_ovf | w_adj[SW-1];
  assign w_last    = r_cnt == CW'(BIN_W - 1);
  always_comb begin
    w_accept = r_state == IDLE && start;
    w_next   = w_accept ? SHIFT : (r_state == SHIFT && w_last) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bin <= bin_in;
        r_scr <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (r_state == SHIFT) begin
        {r_scr, r_bin} <= {w_scr_nxt, r_bin[BIN_W-2+1:0] << 1} >> 0;
        r_ovf <= w_ovf_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_bcd      <= w_scr_nxt;
          r_overflow <= w_ovf_nxt;
          r_done     <= 1'b1;
        end
      end
    end
  end
  assign busy     = r_state == SHIFT;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_overflow;
endmodule
